// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the frame-lock state encoding.
// Used by the sync generator, the pattern generator and vga_sync_to_count,
// so all three agree on the geometry without repeating the numbers.
package vga_timing_pkg;

  // 640x480 @ 60 Hz with a 25 MHz pixel clock
  localparam int DEF_TOTAL_COLS  = 800;
  localparam int DEF_TOTAL_ROWS  = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;

  // Width of the recovered column/row counters
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    UNSEEN = 2'd0,
    ALIGN1 = 2'd1,
    ALIGN2 = 2'd2,
    LOCKED = 2'd3
  } lock_state_e;

endpackage

// File: rtl/sync_lock_tracker.sv
// Frame-lock state machine for vga_sync_to_count.
// Takes the frame-start / HSync edge events and the counter compare results
// from the top level and produces the lock flag and a one-cycle error pulse.
//
// Ports:
//   i_Clk, i_Rst_L      pixel clock, async active-low reset
//   i_frame_start       VSync rising edge this cycle
//   i_frame_good        counters sit at the last col/row of the frame
//   i_h_rise, i_h_fall  HSync rising / falling edge this cycle
//   i_col_line_end      counter at the last column of the line
//   i_col_active_end    counter at the last active column
//   o_Locked            state == LOCKED
//   o_Sync_Err          one-cycle pulse on any timing violation
//
// state  | meaning
// -------+-----------------------------------------------------------
// UNSEEN | no frame start since reset; no checks, first FS just aligns
// ALIGN1 | aligned once (or after an error); waiting for a good FS
// ALIGN2 | one good frame seen; one more good FS locks
// LOCKED | two consecutive good frames; timing confirmed
module sync_lock_tracker
  import vga_timing_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_frame_start,
  input  logic i_frame_good,
  input  logic i_h_rise,
  input  logic i_h_fall,
  input  logic i_col_line_end,
  input  logic i_col_active_end,
  output logic o_Locked,
  output logic o_Sync_Err
);

  lock_state_e state_q, state_d;
  logic        err_q, err_d;
  logic        fs_bad, line_bad;

  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    fs_bad   = i_frame_start && !i_frame_good;
    // An HSync rise coinciding with a frame start is judged by the FS check only.
    line_bad = (i_h_rise && !i_frame_start && !i_col_line_end) ||
               (i_h_fall && !i_col_active_end);

    case (state_q)
      UNSEEN: begin
        if (i_frame_start) state_d = ALIGN1;
      end
      default: begin
        if (fs_bad || line_bad) begin
          err_d   = 1'b1;
          state_d = ALIGN1;
        end else if (i_frame_start) begin
          case (state_q)
            ALIGN1:  state_d = ALIGN2;
            ALIGN2:  state_d = LOCKED;
            default: state_d = LOCKED;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= UNSEEN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign o_Locked   = (state_q == LOCKED);
  assign o_Sync_Err = err_q;

endmodule

// File: rtl/vga_sync_to_count.sv
// Recovers column/row counters from VGA active-region syncs.
// Re-emits the syncs one cycle late, with counts aligned to them, and
// reports frame lock and sync-timing violations.
//
// Ports:
//   i_Clk, i_Rst_L        pixel clock, async active-low reset
//   i_HSync, i_VSync      high during active columns / rows
//   o_HSync, o_VSync      input syncs delayed one cycle
//   o_Col_Count           recovered column, aligned to o_HSync
//   o_Row_Count           recovered row, aligned to o_VSync
//   o_Locked              frame timing confirmed
//   o_Sync_Err            one-cycle pulse on a timing violation
module vga_sync_to_count
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_HSync,
  input  logic             i_VSync,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Locked,
  output logic             o_Sync_Err
);

  localparam logic [CNT_W-1:0] COL_LAST     = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST     = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] COL_ACT_LAST = CNT_W'(ACTIVE_COLS - 1);

  // A geometry the counters cannot represent never yields a good frame,
  // so such a build can never report lock.
  localparam bit GEOMETRY_OK = (ACTIVE_COLS > 0) && (ACTIVE_COLS < TOTAL_COLS) &&
                               (ACTIVE_ROWS > 0) && (ACTIVE_ROWS < TOTAL_ROWS) &&
                               (TOTAL_COLS <= (1 << CNT_W)) &&
                               (TOTAL_ROWS <= (1 << CNT_W));

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             frame_start, h_rise, h_fall;
  logic             at_line_end, at_frame_end, at_active_end;

  always_comb begin
    hsync_d       = i_HSync;
    vsync_d       = i_VSync;
    frame_start   = !vsync_q && i_VSync;
    h_rise        = !hsync_q && i_HSync;
    h_fall        = hsync_q && !i_HSync;
    at_line_end   = (col_q == COL_LAST);
    at_frame_end  = at_line_end && (row_q == ROW_LAST);
    at_active_end = (col_q == COL_ACT_LAST);

    col_d = col_q + CNT_W'(1);
    row_d = row_q;
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (at_line_end) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  sync_lock_tracker u_lock (
    .i_Clk            (i_Clk),
    .i_Rst_L          (i_Rst_L),
    .i_frame_start    (frame_start),
    .i_frame_good     (at_frame_end && GEOMETRY_OK),
    .i_h_rise         (h_rise),
    .i_h_fall         (h_fall),
    .i_col_line_end   (at_line_end),
    .i_col_active_end (at_active_end),
    .o_Locked         (o_Locked),
    .o_Sync_Err       (o_Sync_Err)
  );

  assign o_HSync     = hsync_q;
  assign o_VSync     = vsync_q;
  assign o_Col_Count = col_q;
  assign o_Row_Count = row_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Scoreboard bench for vga_sync_to_count at a small geometry.
// An upstream sync model drives clean and deliberately faulty frames; a
// frame-level reference model pushes the expected outputs per cycle and a
// monitor compares them one cycle later.
module tb_vga_sync_to_count;

  localparam int TC = 10;
  localparam int TR = 6;
  localparam int AC = 8;
  localparam int AR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b0;
  logic       vs = 1'b0;
  logic       o_hs, o_vs, o_lock, o_err;
  logic [9:0] o_col, o_row;

  always #5 clk = ~clk;

  vga_sync_to_count #(
    .TOTAL_COLS  (TC),
    .TOTAL_ROWS  (TR),
    .ACTIVE_COLS (AC),
    .ACTIVE_ROWS (AR)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_HSync     (hs),
    .i_VSync     (vs),
    .o_HSync     (o_hs),
    .o_VSync     (o_vs),
    .o_Col_Count (o_col),
    .o_Row_Count (o_row),
    .o_Locked    (o_lock),
    .o_Sync_Err  (o_err)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [9:0] col;
    logic [9:0] row;
    logic       lock;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_err_exp = 0;
  int   n_err_seen = 0;
  int   n_lock_seen = 0;
  int   n_cycle = 0;

  // Reference model: previous syncs, linear position in the frame, and a
  // count of consecutive good frame starts since the first one.
  bit m_hs = 0, m_vs = 0, m_seen = 0;
  int m_col = 0, m_row = 0, m_good = 0;

  task automatic model_apply(input bit rl, input bit h, input bit v);
    exp_t e;
    bit   fs, rise, fall, bad;
    int   lin;
    e = '0;
    if (!rl) begin
      m_hs = 0; m_vs = 0; m_col = 0; m_row = 0; m_seen = 0; m_good = 0;
    end else begin
      fs   = !m_vs && v;
      rise = !m_hs && h && !fs;
      fall = m_hs && !h;
      bad  = 0;
      if (m_seen) begin
        if (fs && !(m_col == TC-1 && m_row == TR-1)) bad = 1;
        if (rise && m_col != TC-1) bad = 1;
        if (fall && m_col != AC-1) bad = 1;
      end
      if (fs) begin
        m_col = 0;
        m_row = 0;
      end else begin
        lin   = (m_row * TC + m_col + 1) % (TC * TR);
        m_col = lin % TC;
        m_row = lin / TC;
      end
      if (!m_seen) begin
        if (fs) begin
          m_seen = 1;
          m_good = 0;
        end
      end else if (bad) begin
        m_good = 0;
      end else if (fs && m_good < 2) begin
        m_good = m_good + 1;
      end
      m_hs   = h;
      m_vs   = v;
      e.hs   = h;
      e.vs   = v;
      e.col  = 10'(m_col);
      e.row  = 10'(m_row);
      e.lock = m_seen && (m_good == 2);
      e.err  = bad;
      if (bad) n_err_exp++;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rl, input bit h, input bit v);
    @(negedge clk);
    rst_n = rl;
    hs    = h;
    vs    = v;
    model_apply(rl, h, v);
  endtask

  // kind: 0 clean, 1 VSync one line late, 2 short line, 3 VSync held low,
  //       4 reset mid-frame, 5 early HSync rise on one line
  task automatic gen_frame(input int kind, input int first_row);
    int srow, rst_at, k;
    bit h, v, rl;
    srow   = $urandom_range(0, TR-1);
    rst_at = $urandom_range(TC, TC*TR-4);
    for (int r = first_row; r < TR; r++) begin
      for (int c = 0; c < TC; c++) begin
        h  = (c < AC);
        v  = (r < AR);
        rl = 1;
        k  = r * TC + c;
        case (kind)
          1: v = (r >= 1) && (r < AR);
          2: if (r == srow) h = (c < AC-1);
          3: v = 0;
          4: if (k >= rst_at && k < rst_at + 3) rl = 0;
          5: if (r == srow && c == TC-1) h = 1;
          default: ;
        endcase
        drive(rl, h, v);
      end
    end
  endtask

  // Monitor: one expectation per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cycle++;
        n_checks++;
        if ({o_hs, o_vs, o_col, o_row} !== {e.hs, e.vs, e.col, e.row}) begin
          n_fail++;
          $display("FAIL counts cyc=%0d: got hs=%0b vs=%0b col=%0d row=%0d, want hs=%0b vs=%0b col=%0d row=%0d",
                   n_cycle, o_hs, o_vs, o_col, o_row, e.hs, e.vs, e.col, e.row);
        end
        n_checks++;
        if ({o_lock, o_err} !== {e.lock, e.err}) begin
          n_fail++;
          $display("FAIL flags cyc=%0d: got locked=%0b err=%0b, want locked=%0b err=%0b",
                   n_cycle, o_lock, o_err, e.lock, e.err);
        end
        if (o_err === 1'b1) n_err_seen++;
        if (o_lock === 1'b1) n_lock_seen++;
      end
    end
  end

  int directed[] = '{0, 0, 0, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0,
                     3, 3, 3, 0, 0, 0, 5, 0, 0, 0};

  initial begin
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    // Leave reset in vertical blanking so the first FS is a true frame start.
    gen_frame(0, AR);
    foreach (directed[i]) gen_frame(directed[i], 0);
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = $urandom_range(0, 11);
      gen_frame((sel < 6) ? 0 : sel - 6, 0);
    end

    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
    end
    n_checks++;
    if (n_err_seen != n_err_exp) begin
      n_fail++;
      $display("FAIL err_pulses: got %0d, want %0d", n_err_seen, n_err_exp);
    end
    n_checks++;
    if (n_lock_seen == 0 || n_err_seen == 0) begin
      n_fail++;
      $display("FAIL coverage: got locked_cycles=%0d err_pulses=%0d, want both nonzero",
               n_lock_seen, n_err_seen);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, want completion before 2000000");
    $fatal(1, "timeout");
  end

endmodule
